led_bar_decoder: RTL and testbench
==================================

// Module: led_bar_decoder
// PURPOSE
//  Receive-side decoder for the 16-LED bound-flasher bar. It watches the LED vector and
//  reconstructs the flasher's motion from it: lit level, direction, turn-around points and
//  completed runs. It flags illegal codes and illegal steps.
//  Sits beside boundFlasher in the top level, or in the bench, as a live protocol checker.
// PARAMETERS
//  WIDTH  16  number of LEDs; L0 is led_input[0] and lights first
//  LVL_W  5   level width; must equal clog2(WIDTH+1)
//  CNT_W  8   turn-around counter width
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-low
//  led_input   in   WIDTH  LED vector from the flasher
//  level       out  LVL_W  number of lit LEDs (0..WIDTH), last legal value
//  code_ok     out  1      1 = current sample is a legal thermometer code
//  dir_up      out  1      FSM in RISE
//  dir_down    out  1      FSM in FALL
//  turn_pulse  out  1      1-cycle pulse on a direction reversal
//  peak_level  out  LVL_W  level at the most recent RISE->FALL turn
//  err_pulse   out  1      1-cycle pulse on an illegal code or illegal step
//  err_code    out  2      00 none, 01 non-thermometer, 10 step>1, 11 both
//  run_done    out  1      1-cycle pulse when level returns to 0 after reaching WIDTH
//  turn_count  out  CNT_W  reversals since reset; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=0) clears all outputs and registers asynchronously: level=0, code_ok=1,
//    flags=0, peak=0, count=0, FSM=IDLE.
//  - Pipeline: led_input is registered into led_q. Decoding is combinational from led_q.
//    Outputs are registered on the next edge, so latency is 2 clk from an LED change.
//  - Legal code: led_q == (1<<n)-1 for some n in 0..WIDTH, giving new level n. Any other
//    code is illegal: code_ok=0, err 01, level holds its last legal value, FSM holds.
//  - Step d = n - level. |d| > 1 gives err 10. level still takes n. The FSM resyncs with no
//    turn: d>1 -> RISE, d<-1 -> FALL, n==0 -> IDLE.
//  - FSM IDLE/RISE/FALL, applied only on legal samples with |d| <= 1. d==0 always holds.
//    IDLE: d=+1 -> RISE.
//    RISE: d=-1 -> FALL, turn_pulse=1, peak_level=old level.
//    FALL: d=+1 -> RISE, turn_pulse=1 (kick-back). d=-1 to n==0 -> IDLE.
//  - A "reached max" flag sets when level==WIDTH and clears on entry to IDLE. Entering
//    IDLE with the flag set pulses run_done.
//  - turn_count increments on each turn_pulse and saturates; it never wraps.
//  - Input and error on the same cycle: error behaviour wins. No turn pulse and no count.
//  - Asserting rst mid-run returns to the reset state immediately. The first legal sample
//    after release is evaluated from IDLE with level 0.
// CONFIGURATION
//  LED_DEC_STICKY_ERR_EN
//   defined:   err_code is sticky, OR-accumulating until reset. err_pulse still pulses per
//              event.
//   undefined: err_code reflects only the current cycle and is 00 otherwise.
// TESTING
//  1. Reset: rst=0 with random led_input -> all outputs at reset values, code_ok=1.
//  2. Ramp: led 0x0000 -> 0x003F one step per 10 clk, then down to 0x0000 ->
//     turn_pulse once at 0x003F->0x001F, peak_level=6, dir_down, then IDLE, run_done=0.
//  3. Full run: 0x0000 up to 0xFFFF and back down to 0x0000 -> peak_level=16,
//     run_done pulses once 2 clk after 0x0000, turn_count=1.
//  4. Kick-back: falling at 0x001F (level 5), then 0x003F -> turn_pulse, dir_up,
//     turn_count +1.
//  5. Errors: led=0x0005 -> err_code=01, level held. Then 0x0003 -> 0x00FF gives
//     err_code=10 and level=8, with no turn. Rerun both with LED_DEC_STICKY_ERR_EN and
//     expect err_code=11 held.
//  6. Mid-run reset: level=10, rst low for 3 clk -> outputs cleared. After release, led
//     0x0001 -> dir_up, level=1, no error.

Source files
------------

// File: rtl/led_bar_decoder.sv
// ---------------------------------------------------------------------------
// LedBarDecoder (module led_bar_decoder)
//
// Receive-side decoder for the bound-flasher LED bar. It watches the LED
// vector, rebuilds the flasher's motion from it (lit level, direction,
// turn-around points, completed runs) and flags illegal codes and illegal
// steps. Intended as a live protocol checker beside the flasher.
//
// Ports:
//    clk         rising-edge clock
//    rst         asynchronous reset, active-low
//    led_input   LED vector from the flasher (bit 0 lights first)
//    level       number of lit LEDs, last legal value
//    code_ok     current sample is a legal thermometer code
//    dir_up      FSM is in RISE
//    dir_down    FSM is in FALL
//    turn_pulse  one-cycle pulse on a direction reversal
//    peak_level  level at the most recent RISE->FALL turn
//    err_pulse   one-cycle pulse on an illegal code or illegal step
//    err_code    00 none, 01 non-thermometer, 10 step>1, 11 both
//    run_done    one-cycle pulse when level returns to 0 after reaching WIDTH
//    turn_count  reversals since reset, saturating
//
// Build option:
//    LED_DEC_STICKY_ERR_EN  when defined, err_code OR-accumulates until reset;
//                           otherwise it shows only the current cycle's error.
// ---------------------------------------------------------------------------
module led_bar_decoder #(
   parameter int WIDTH = 16,
   parameter int LVL_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led_input,
   output logic [LVL_W-1:0] level,
   output logic             code_ok,
   output logic             dir_up,
   output logic             dir_down,
   output logic             turn_pulse,
   output logic [LVL_W-1:0] peak_level,
   output logic             err_pulse,
   output logic [1:0]       err_code,
   output logic             run_done,
   output logic [CNT_W-1:0] turn_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]        LED_ONE  = WIDTH'(1);
   localparam logic [LVL_W-1:0]        FULL_LVL = LVL_W'(WIDTH);
   localparam logic [LVL_W-1:0]        ZERO_LVL = '0;
   localparam logic signed [LVL_W:0]   STEP_P1  = (LVL_W+1)'(1);
   localparam logic signed [LVL_W:0]   STEP_M1  = -(LVL_W+1)'(1);
   localparam logic [CNT_W-1:0]        CNT_MAX  = '1;

   state_t                 state;
   state_t                 state_next;
   logic [WIDTH-1:0]       led_q;
   logic [LVL_W-1:0]       lit_count;
   logic                   is_therm;
   logic signed [LVL_W:0]  step;
   logic                   step_up;
   logic                   step_down;
   logic                   step_big;
   logic                   reached_max;
   logic                   max_next;
   logic [LVL_W-1:0]       level_next;
   logic [LVL_W-1:0]       peak_next;
   logic                   turn_next;
   logic                   run_next;
   logic [1:0]             err_next;
   logic [1:0]             err_code_next;

   // A thermometer code x = 2^n - 1 is exactly the value for which x+1 has
   // no bits in common with x (all-ones wraps to zero and still qualifies).
   // The lit level is then simply the number of ones.
   always_comb begin
      is_therm  = ((led_q & (led_q + LED_ONE)) == '0);
      lit_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lit_count = lit_count + LVL_W'(led_q[i]);
      end
   end

   // Signed step between the decoded level and the last legal level.
   always_comb begin
      step      = $signed({1'b0, lit_count}) - $signed({1'b0, level});
      step_up   = (step == STEP_P1);
      step_down = (step == STEP_M1);
      step_big  = (step > STEP_P1) || (step < STEP_M1);
   end

   // Next-state and next-output logic. An illegal code freezes the level and
   // the FSM. A jump of more than one LED is reported but still accepted: the
   // FSM resynchronises to the jump direction without declaring a turn, so a
   // glitchy flasher does not inflate the turn statistics.
   always_comb begin
      state_next = state;
      level_next = level;
      peak_next  = peak_level;
      turn_next  = 1'b0;
      run_next   = 1'b0;
      err_next   = 2'b00;
      max_next   = reached_max;

      if (!is_therm) begin
         err_next = 2'b01;
      end else begin
         level_next = lit_count;
         if (step_big) begin
            err_next = 2'b10;
            if (lit_count == ZERO_LVL) begin
               state_next = IDLE;
            end else if (step > STEP_P1) begin
               state_next = RISE;
            end else begin
               state_next = FALL;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (step_up) begin
                     state_next = RISE;
                  end
               end
               RISE: begin
                  if (step_down) begin
                     state_next = FALL;
                     turn_next  = 1'b1;
                     peak_next  = level;
                  end
               end
               FALL: begin
                  if (step_up) begin
                     state_next = RISE;
                     turn_next  = 1'b1;
                  end else if (step_down && (lit_count == ZERO_LVL)) begin
                     state_next = IDLE;
                  end
               end
               default: begin
                  state_next = IDLE;
               end
            endcase
         end

         if (lit_count == FULL_LVL) begin
            max_next = 1'b1;
         end
         if ((state_next == IDLE) && (state != IDLE)) begin
            run_next = reached_max;
            max_next = 1'b0;
         end
      end
   end

   // Error code presentation: either the current cycle only, or an
   // accumulated history that only reset can clear.
   always_comb begin
`ifdef LED_DEC_STICKY_ERR_EN
      err_code_next = err_code | err_next;
`else
      err_code_next = err_next;
`endif
   end

   // Input register: decoding always works from a stable captured sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q <= '0;
      end else begin
         led_q <= led_input;
      end
   end

   // State and output registers, one edge after the captured sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         level       <= '0;
         code_ok     <= 1'b1;
         turn_pulse  <= 1'b0;
         peak_level  <= '0;
         err_pulse   <= 1'b0;
         err_code    <= 2'b00;
         run_done    <= 1'b0;
         turn_count  <= '0;
         reached_max <= 1'b0;
      end else begin
         state       <= state_next;
         level       <= level_next;
         code_ok     <= is_therm;
         turn_pulse  <= turn_next;
         peak_level  <= peak_next;
         err_pulse   <= (err_next != 2'b00);
         err_code    <= err_code_next;
         run_done    <= run_next;
         reached_max <= max_next;
         if (turn_next && (turn_count != CNT_MAX)) begin
            turn_count <= turn_count + CNT_W'(1);
         end
      end
   end

   assign dir_up   = (state == RISE);
   assign dir_down = (state == FALL);

endmodule

// File: tb/tb_led_bar_decoder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for led_bar_decoder. A behavioural model tracks the
// expected level, direction and counters from the LED samples; every cycle
// all outputs are compared against it, plus directed checks on key points.
// ---------------------------------------------------------------------------
module tb_led_bar_decoder;

   localparam int WIDTH = 16;
   localparam int LVL_W = 5;
   localparam int CNT_W = 8;
`ifdef LED_DEC_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] led;
   logic [LVL_W-1:0] level;
   logic             codeOk;
   logic             dirUp;
   logic             dirDown;
   logic             turnPulse;
   logic [LVL_W-1:0] peakLevel;
   logic             errPulse;
   logic [1:0]       errCode;
   logic             runDone;
   logic [CNT_W-1:0] turnCount;

   int checks;
   int errors;
   int turnSeen;
   int runSeen;

   // Reference model state (direction: 0 idle, 1 up, 2 down)
   logic [WIDTH-1:0] mLedq;
   int               mLevel;
   int               mDir;
   int               mPeak;
   int               mCount;
   bit               mMax;
   bit               mCodeOk;
   bit               mTurn;
   bit               mErr;
   bit               mRun;
   logic [1:0]       mErrCode;

   led_bar_decoder #(.WIDTH(WIDTH), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .led_input  (led),
      .level      (level),
      .code_ok    (codeOk),
      .dir_up     (dirUp),
      .dir_down   (dirDown),
      .turn_pulse (turnPulse),
      .peak_level (peakLevel),
      .err_pulse  (errPulse),
      .err_code   (errCode),
      .run_done   (runDone),
      .turn_count (turnCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] therm(input int n);
      logic [31:0] v;
      v = (32'd1 << n) - 32'd1;
      return v[WIDTH-1:0];
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mLedq    = '0;
      mLevel   = 0;
      mDir     = 0;
      mPeak    = 0;
      mCount   = 0;
      mMax     = 1'b0;
      mCodeOk  = 1'b1;
      mTurn    = 1'b0;
      mErr     = 1'b0;
      mRun     = 1'b0;
      mErrCode = 2'b00;
   endtask

   // One clock of the flasher-motion rules applied to the captured sample.
   task automatic modelEdge();
      int         n;
      int         d;
      int         nextDir;
      bit         legal;
      logic [1:0] e;
      n       = $countones(mLedq);
      legal   = (mLedq == therm(n));
      mTurn   = 1'b0;
      mRun    = 1'b0;
      e       = 2'b00;
      mCodeOk = legal;
      if (!legal) begin
         e = 2'b01;
      end else begin
         d       = n - mLevel;
         nextDir = mDir;
         if (d > 1 || d < -1) begin
            e       = 2'b10;
            nextDir = (n == 0) ? 0 : ((d > 0) ? 1 : 2);
         end else if (d == 1) begin
            if (mDir == 2) mTurn = 1'b1;
            nextDir = 1;
         end else if (d == -1) begin
            if (mDir == 1) begin
               mTurn   = 1'b1;
               mPeak   = mLevel;
               nextDir = 2;
            end else if (mDir == 2 && n == 0) begin
               nextDir = 0;
            end
         end
         if (n == WIDTH) mMax = 1'b1;
         if (nextDir == 0 && mDir != 0) begin
            mRun = mMax;
            mMax = 1'b0;
         end
         mDir   = nextDir;
         mLevel = n;
         if (mTurn && mCount < 255) mCount++;
      end
      mErr     = (e != 2'b00);
      mErrCode = STICKY ? (mErrCode | e) : e;
      mLedq    = led;
   endtask

   task automatic checkOutput();
      checkVal("level",      level,     mLevel);
      checkVal("code_ok",    codeOk,    mCodeOk);
      checkVal("dir_up",     dirUp,     mDir == 1);
      checkVal("dir_down",   dirDown,   mDir == 2);
      checkVal("turn_pulse", turnPulse, mTurn);
      checkVal("peak_level", peakLevel, mPeak);
      checkVal("err_pulse",  errPulse,  mErr);
      checkVal("err_code",   errCode,   mErrCode);
      checkVal("run_done",   runDone,   mRun);
      checkVal("turn_count", turnCount, mCount);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) modelReset();
      else      modelEdge();
      #1;
      if (turnPulse === 1'b1) turnSeen++;
      if (runDone === 1'b1)   runSeen++;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] value, input int cycles);
      led = value;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b0;
      led = WIDTH'($urandom);
      #1;
      modelReset();
      checkOutput();
      for (int i = 0; i < cycles; i++) begin
         led = WIDTH'($urandom);
         tick();
      end
      rst      = 1'b1;
      led      = '0;
      turnSeen = 0;
      runSeen  = 0;
   endtask

   initial begin
      int cur;
      int r;
      checks   = 0;
      errors   = 0;
      turnSeen = 0;
      runSeen  = 0;
      rst      = 1'b0;
      led      = '0;
      modelReset();
      @(posedge clk);
      #1;

      $display("[TB] reset with random LEDs");
      doReset(4);
      checkVal("rst_code_ok", codeOk, 1);
      checkVal("rst_level", level, 0);

      $display("[TB] ramp to 6 and back");
      for (int n = 1; n <= 6; n++) applyStimulus(therm(n), 10);
      for (int n = 5; n >= 0; n--) begin
         applyStimulus(therm(n), 10);
         if (n == 5) begin
            checkVal("ramp_peak", peakLevel, 6);
            checkVal("ramp_dir_down", dirDown, 1);
         end
      end
      checkVal("ramp_turns", turnSeen, 1);
      checkVal("ramp_idle", {30'd0, dirUp, dirDown}, 0);
      checkVal("ramp_no_run", runSeen, 0);

      $display("[TB] full run");
      doReset(2);
      for (int n = 1; n <= WIDTH; n++) applyStimulus(therm(n), 10);
      for (int n = WIDTH - 1; n >= 1; n--) applyStimulus(therm(n), 10);
      applyStimulus('0, 1);
      checkVal("full_run_early", runDone, 0);
      tick();
      checkVal("full_run_done", runDone, 1);
      applyStimulus('0, 5);
      checkVal("full_peak", peakLevel, 16);
      checkVal("full_count", turnCount, 1);
      checkVal("full_run_once", runSeen, 1);

      $display("[TB] kick-back");
      doReset(2);
      for (int n = 1; n <= 6; n++) applyStimulus(therm(n), 3);
      applyStimulus(16'h001F, 3);
      applyStimulus(16'h003F, 3);
      checkVal("kick_dir_up", dirUp, 1);
      checkVal("kick_count", turnCount, 2);
      checkVal("kick_turns", turnSeen, 2);

      $display("[TB] error codes");
      doReset(2);
      applyStimulus(16'h0001, 3);
      applyStimulus(16'h0003, 3);
      applyStimulus(16'h0005, 2);
      checkVal("err_nontherm", errCode, 2'b01);
      checkVal("err_level_held", level, 2);
      checkVal("err_code_ok", codeOk, 0);
      applyStimulus(16'h0003, 3);
      applyStimulus(16'h00FF, 2);
      checkVal("err_step", errCode, STICKY ? 2'b11 : 2'b10);
      checkVal("err_step_level", level, 8);
      checkVal("err_no_turn", turnSeen, 0);
      applyStimulus(16'h00FF, 3);
      checkVal("err_after", errCode, STICKY ? 2'b11 : 2'b00);

      $display("[TB] mid-run reset");
      doReset(2);
      for (int n = 1; n <= 10; n++) applyStimulus(therm(n), 2);
      checkVal("mid_level", level, 10);
      doReset(3);
      checkVal("mid_cleared", level, 0);
      applyStimulus(16'h0001, 2);
      checkVal("mid_dir_up", dirUp, 1);
      checkVal("mid_level1", level, 1);
      checkVal("mid_no_err", errCode, 0);

      $display("[TB] turn counter saturation");
      doReset(2);
      applyStimulus(therm(1), 2);
      applyStimulus(therm(2), 2);
      applyStimulus(therm(3), 2);
      for (int k = 0; k < 140; k++) begin
         applyStimulus(therm(4), 2);
         applyStimulus(therm(3), 2);
      end
      checkVal("sat_count", turnCount, 255);

      $display("[TB] randomized walk");
      doReset(2);
      cur = 0;
      for (int k = 0; k < 600; k++) begin
         r = int'($urandom_range(0, 99));
         if (r == 99) begin
            doReset(int'($urandom_range(1, 3)));
            cur = 0;
         end else if (r < 75) begin
            if ($urandom_range(0, 1) == 1) cur = (cur < WIDTH) ? cur + 1 : cur - 1;
            else                           cur = (cur > 0) ? cur - 1 : cur + 1;
            applyStimulus(therm(cur), int'($urandom_range(1, 3)));
         end else if (r < 88) begin
            cur = int'($urandom_range(0, WIDTH));
            applyStimulus(therm(cur), int'($urandom_range(1, 3)));
         end else begin
            applyStimulus(WIDTH'($urandom), int'($urandom_range(1, 2)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
